fp_mul_seq: RTL
===============

Name: fp_mul_seq

Overview:
Parametrised, sequential IEEE-754-style floating-point multiplier. It is the successor to the combinational half-precision multiplier in the arithmetic datapath.
- Generalised exponent and mantissa widths.
- Iterative shift-add mantissa multiply with valid/ready handshakes on both sides.
- Result classification flags compatible with the existing multiplier's flag set.

Parameters:
EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
MAN_W, 10, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands present
in_ready  out  1  block can accept operands
na  in  W  operand A
nb  in  W  operand B
out_valid  out  1  product and flags valid
out_ready  in  1  consumer takes result
producto  out  W  product
snan  out  1  an input was a signalling NaN
qnan  out  1  result is NaN
inf  out  1  result is ±infinity
zero  out  1  result is ±zero
subnormal  out  1  true result underflowed and was flushed to zero
normal  out  1  result is a normal number

Behaviour:
Reset:
- State goes to IDLE.
- in_ready=1, out_valid=0, producto=0, all flags 0.
- Reset mid-operation discards the operation in flight.

Handshake:
- Operands are accepted on a cycle where in_valid && in_ready.
- in_ready=1 only in IDLE.
- out_valid holds, with producto and flags stable, until out_ready; the transfer completes on out_valid && out_ready.
- The next cycle returns to IDLE. No new operation is accepted in that same cycle.

FSM states: IDLE, MUL, NORM, ROUND, DONE.
- IDLE → DONE when either operand is special. Result is registered on the accept edge; out_valid rises 1 cycle after accept.
- IDLE → MUL otherwise.
- MUL: MAN_W+1 cycles, one bit of {1,man_b} per cycle, accumulating {1,man_a} into a 2*(MAN_W+1)-bit product.
- MUL → NORM (1 cycle) → ROUND (1 cycle) → DONE.
- Normal-path latency: out_valid asserts MAN_W+4 cycles after the accept edge (14 at defaults).

Special operands (checked in priority order):
- Exponent field 0 is treated as zero; subnormal inputs are flushed.
- Any NaN, or inf×0 → canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0 (0x7E00 default). qnan=1.
- snan=1 if either input has exponent all ones, fraction nonzero and fraction MSB 0.
- inf×finite-nonzero → ±inf, inf=1.
- zero×finite → ±zero, zero=1.
- Sign is always na[W-1]^nb[W-1] except for NaN.

Arithmetic:
- Exponent sum ea+eb-bias is computed in EXP_W+2 bits, signed.
- Product MSB set → shift right 1 and increment exponent (NORM).
- ROUND packs the result, with rounding per the optional feature.
- Rounding carry-out of the mantissa → exponent+1.
- Final exponent ≥ 2^EXP_W-1 → ±inf, inf=1.
- Final exponent ≤ 0 → ±zero, zero=1, subnormal=1.
- Otherwise normal=1.

Flags: exactly one of qnan/inf/zero/normal is set per valid result. snan may accompany qnan; subnormal may accompany zero.

Optional Feature:
Macro: FP_MUL_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Guard = first dropped bit; sticky = OR of the remaining dropped bits. Increment when guard && (sticky || lsb).
- Undefined: truncation, bit-compatible with the existing multiplier. Latency and the ROUND state are identical in both builds.

Test Plan:
- Reset, then na=0x4000, nb=0x4200 (2×3) → producto=0x4600, normal=1, out_valid exactly 14 cycles after accept; in_ready=0 throughout.
- na=0x5C01, nb=0x4B2E → 0x6B2F without FP_MUL_ROUND_NEAREST_EN, 0x6B30 with it. Also na=0xD0A0, nb=0x4AA1 → 0xDFAA truncated.
- Special cases, each with out_valid 1 cycle after accept:
  - 0x7C00 × 0x0000 → 0x7E00, qnan=1.
  - 0x7D00 × 0x3C00 → 0x7E00, snan=1, qnan=1.
  - 0x7C00 × 0x3C66 → 0x7C00, inf=1.
  - 0x409A × 0x0000 → 0x0000, zero=1.
- Boundary results:
  - 0x5FD1 × 0x5BAD → 0x7C00, inf=1 (overflow).
  - 0x0400 × 0x3800 → 0x0000, zero=1, subnormal=1 (underflow flush).
- Backpressure: out_ready held low 20 cycles after out_valid → producto/flags stable, in_ready=0. Raise out_ready → out_valid drops next cycle; back-to-back in_valid is accepted the following cycle.
- Assert rst during MUL cycle 5 → next cycle out_valid=0, in_ready=1. A fresh 0x4500×0x4500 then yields 0x4E40.

Source files
------------

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential shift-add floating-point multiplier with result flags.
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.

module fp_mul_seq #(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] na,
    input  logic [W-1:0] nb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] producto,
    output logic         snan,
    output logic         qnan,
    output logic         inf,
    output logic         zero,
    output logic         subnormal,
    output logic         normal
);

    localparam int SIG_W = MAN_W + 1;
    localparam int P_W   = 2 * SIG_W;
    localparam int E_W   = EXP_W + 2;
    localparam int CNT_W = $clog2(SIG_W + 1);
    localparam int BIAS  = 2 ** (EXP_W - 1) - 1;

    localparam logic [E_W-1:0]   BIAS_V   = E_W'(BIAS);
    localparam logic [E_W-1:0]   EMAX_V   = E_W'(2 ** EXP_W - 1);
    localparam logic [E_W-1:0]   E_ONE    = E_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [W-1:0] QNAN_V =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // flag vector order: {snan, qnan, inf, zero, subnormal, normal}
    localparam logic [5:0] F_INF  = 6'b001000;
    localparam logic [5:0] F_ZERO = 6'b000100;
    localparam logic [5:0] F_UNF  = 6'b000110;
    localparam logic [5:0] F_NORM = 6'b000001;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_emax, b_emax;
    logic             a_nan, b_nan;
    logic             a_snan, b_snan;
    logic             a_inf, b_inf;
    logic             a_zero, b_zero;
    logic             spec;
    logic             res_sgn;

    logic [W-1:0]     spec_p;
    logic [5:0]       spec_f;

    logic             sgn;
    logic [P_W-1:0]   mcand;
    logic [SIG_W-1:0] mplr;
    logic [P_W-1:0]   prod;
    logic [E_W-1:0]   ex;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       flg;

    logic [SIG_W:0]   mant_r;
    logic             rnd_inc;
    logic [E_W-1:0]   ex_f;
    logic             ovf, unf;
    logic [W-1:0]     rnd_p;
    logic [5:0]       rnd_f;

    assign ea = na[W-2:MAN_W];
    assign eb = nb[W-2:MAN_W];
    assign fa = na[MAN_W-1:0];
    assign fb = nb[MAN_W-1:0];

    assign a_emax = &ea;
    assign b_emax = &eb;
    assign a_nan  = a_emax & (|fa);
    assign b_nan  = b_emax & (|fb);
    assign a_snan = a_nan & ~fa[MAN_W-1];
    assign b_snan = b_nan & ~fb[MAN_W-1];
    assign a_inf  = a_emax & ~(|fa);
    assign b_inf  = b_emax & ~(|fb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);

    assign spec    = a_emax | b_emax | a_zero | b_zero;
    assign res_sgn = na[W-1] ^ nb[W-1];

    assign {snan, qnan, inf, zero, subnormal, normal} = flg;

    always_comb begin
        spec_p = '0;
        spec_f = '0;
        priority case (1'b1)
            (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)): begin
                spec_p = QNAN_V;
                spec_f = {a_snan | b_snan, 1'b1, 4'b0000};
            end
            (a_inf | b_inf): begin
                spec_p = {res_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                spec_f = F_INF;
            end
            default: begin
                spec_p = {res_sgn, {(W-1){1'b0}}};
                spec_f = F_ZERO;
            end
        endcase
    end

`ifdef FP_MUL_ROUND_NEAREST_EN
    logic lost;
    logic guard;
    logic sticky;

    // the bit shifted out during normalisation still counts toward sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            lost <= 1'b0;
        end else if (state == IDLE) begin
            lost <= 1'b0;
        end else if (state == NORM && prod[P_W-1]) begin
            lost <= prod[0];
        end
    end

    assign guard   = prod[MAN_W-1];
    assign sticky  = (|prod[MAN_W-2:0]) | lost;
    assign rnd_inc = guard & (sticky | prod[MAN_W]);
`else
    assign rnd_inc = 1'b0;
`endif

    assign mant_r = {1'b0, 1'b1, prod[P_W-3 -: MAN_W]}
                  + {{SIG_W{1'b0}}, rnd_inc};
    assign ex_f   = ex + {{(E_W-1){1'b0}}, mant_r[SIG_W]};
    assign ovf    = ~ex_f[E_W-1] & (ex_f >= EMAX_V);
    assign unf    = ex_f[E_W-1] | (ex_f == '0);

    always_comb begin
        rnd_p = '0;
        rnd_f = '0;
        priority case (1'b1)
            ovf: begin
                rnd_p = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                rnd_f = F_INF;
            end
            unf: begin
                rnd_p = {sgn, {(W-1){1'b0}}};
                rnd_f = F_UNF;
            end
            default: begin
                rnd_p = {sgn, ex_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
                rnd_f = F_NORM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = spec ? DONE : MUL;
                end
            end
            MUL: begin
                if (cnt == CNT_LAST) begin
                    state_nx = NORM;
                end
            end
            NORM:  state_nx = ROUND;
            ROUND: state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sgn      <= 1'b0;
            mcand    <= '0;
            mplr     <= '0;
            prod     <= '0;
            ex       <= '0;
            cnt      <= '0;
            producto <= '0;
            flg      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn   <= res_sgn;
                        mcand <= {{SIG_W{1'b0}}, 1'b1, fa};
                        mplr  <= {1'b1, fb};
                        prod  <= '0;
                        cnt   <= '0;
                        ex    <= {2'b00, ea} + {2'b00, eb} - BIAS_V;
                        if (spec) begin
                            producto <= spec_p;
                            flg      <= spec_f;
                        end
                    end
                end
                MUL: begin
                    if (mplr[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CNT_ONE;
                end
                NORM: begin
                    if (prod[P_W-1]) begin
                        prod <= prod >> 1;
                        ex   <= ex + E_ONE;
                    end
                end
                ROUND: begin
                    producto <= rnd_p;
                    flg      <= rnd_f;
                end
                default: ;
            endcase
        end
    end

endmodule
